// File: rtl/afe_flag_queue.sv
// rtl/afe_flag_queue.sv - flag record FIFO with per-channel mask, coalesced event and overflow count
module afe_flag_queue #(
    parameter int NUM_CHS    = 8,
    parameter int CHID_WIDTH = 4,
    parameter int FLAG_WIDTH = 4,
    parameter int PTR_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_en_i,
    input  logic [NUM_CHS*FLAG_WIDTH-1:0] cfg_flag_mask_i,
    input  logic [CNT_WIDTH-1:0]          cfg_evt_thresh_i,
    input  logic                          cfg_clr_i,
    input  logic                          smpl_valid_i,
    input  logic [CHID_WIDTH-1:0]         smpl_chid_i,
    input  logic [FLAG_WIDTH-1:0]         smpl_flags_i,
    input  logic [PTR_WIDTH-1:0]          smpl_wr_ptr_i,
    output logic                          flag_valid_o,
    input  logic                          flag_ready_i,
    output logic [31:0]                   flag_data_o,
    output logic                          event_o,
    output logic [CNT_WIDTH-1:0]          evt_cnt_o,
    output logic [CNT_WIDTH-1:0]          ovfl_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [0:0] ST_ARMED = 1'b0;
    localparam logic [0:0] ST_FIRED = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [31:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]        lvl_q, lvl_d;
    logic [0:0]           state_q, state_d;
    logic                 event_q, event_d;
    logic [CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d, ovfl_q, ovfl_d;

    logic [FLAG_WIDTH-1:0] mask_sel;
    logic                  chid_ok, hit, empty, full, pop, push, drop;
    logic [31:0]           rec;
    logic [CNT_WIDTH-1:0]  thr, base, cnt_n;
    logic                  armed, fire;

    always_comb begin
        mask_sel = '0;
        for (int c = 0; c < NUM_CHS; c++) begin
            if (32'(smpl_chid_i) == c) mask_sel = cfg_flag_mask_i[c*FLAG_WIDTH +: FLAG_WIDTH];
        end
    end

    assign chid_ok = 32'(smpl_chid_i) < NUM_CHS;
    assign hit     = cfg_en_i & smpl_valid_i & chid_ok & (|(smpl_flags_i & mask_sel));
    assign empty   = (lvl_q == '0);
    assign full    = (lvl_q == LW'(FIFO_DEPTH));
    assign pop     = ~empty & flag_ready_i;
    assign push    = hit & (~full | pop);
    assign drop    = hit & full & ~pop;
    assign rec     = {8'(smpl_chid_i), 8'(smpl_flags_i), 16'(smpl_wr_ptr_i)};

    always_comb begin
        rd_d  = pop  ? rd_q + 1'b1 : rd_q;
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        lvl_d = lvl_q;
        if (push && !pop) lvl_d = lvl_q + 1'b1;
        else if (pop && !push) lvl_d = lvl_q - 1'b1;
    end

    // A clear restarts the count from zero in the same cycle, so a coincident pop counts as 1.
    always_comb begin
        thr       = (cfg_evt_thresh_i == '0) ? CNT_WIDTH'(1) : cfg_evt_thresh_i;
        base      = cfg_clr_i ? '0 : evt_cnt_q;
        armed     = cfg_clr_i | (state_q == ST_ARMED);
        cnt_n     = (base == CNT_MAX) ? base : base + 1'b1;
        fire      = pop & armed & (cnt_n >= thr) & ~event_q;
        evt_cnt_d = pop ? cnt_n : base;
        event_d   = fire;
        state_d   = state_q;
        if (fire) state_d = ST_FIRED;
        else if (cfg_clr_i) state_d = ST_ARMED;
        ovfl_d = cfg_clr_i ? '0 : ovfl_q;
        if (drop && ovfl_d != CNT_MAX) ovfl_d = ovfl_d + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= rec;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q      <= '0;
            wr_q      <= '0;
            lvl_q     <= '0;
            state_q   <= ST_ARMED;
            event_q   <= 1'b0;
            evt_cnt_q <= '0;
            ovfl_q    <= '0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            lvl_q     <= lvl_d;
            state_q   <= state_d;
            event_q   <= event_d;
            evt_cnt_q <= evt_cnt_d;
            ovfl_q    <= ovfl_d;
        end
    end

    assign flag_valid_o = ~empty;
    assign flag_data_o  = empty ? 32'h0 : mem_q[rd_q];
    assign event_o      = event_q;
    assign evt_cnt_o    = evt_cnt_q;
    assign ovfl_cnt_o   = ovfl_q;
    assign fifo_level_o = lvl_q;
endmodule

// File: tb/tb_afe_flag_queue.sv
// tb/tb_afe_flag_queue.sv - randomized and directed bench for afe_flag_queue against a queue model
module tb_afe_flag_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] mask = '0;
    logic [5:0]  thresh = 6'd63;
    logic        clr = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  chid = '0;
    logic [3:0]  flags = '0;
    logic [15:0] ptr = '0;
    logic        ready = 1'b0;
    logic        fv, ev;
    logic [31:0] fd;
    logic [5:0]  ecnt, ocnt;
    logic [2:0]  lvl;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    int  m_evt = 0, m_ovfl = 0;
    bit  m_fired = 0, m_ev = 0;

    always #5 clk = ~clk;

    afe_flag_queue dut (
        .clk_i(clk), .rst_i(rst), .cfg_en_i(en), .cfg_flag_mask_i(mask),
        .cfg_evt_thresh_i(thresh), .cfg_clr_i(clr), .smpl_valid_i(valid),
        .smpl_chid_i(chid), .smpl_flags_i(flags), .smpl_wr_ptr_i(ptr),
        .flag_valid_o(fv), .flag_ready_i(ready), .flag_data_o(fd), .event_o(ev),
        .evt_cnt_o(ecnt), .ovfl_cnt_o(ocnt), .fifo_level_o(lvl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model advances one clock from the present inputs, then the DUT is compared after the edge.
    task automatic cycle();
        bit pop, hit, full, nev;
        int th;
        if (rst) begin
            q.delete(); m_evt = 0; m_ovfl = 0; m_fired = 0; m_ev = 0;
        end else begin
            pop  = (q.size() > 0) && ready;
            hit  = en && valid && (chid < 8) && ((flags & mask[chid*4 +: 4]) != 0);
            full = (q.size() == 4);
            th   = (thresh == 0) ? 1 : int'(thresh);
            nev  = 0;
            if (pop) void'(q.pop_front());
            if (clr) begin m_evt = 0; m_ovfl = 0; m_fired = 0; end
            if (hit) begin
                if (!full || pop) q.push_back({4'h0, chid, 4'h0, flags, ptr});
                else if (m_ovfl < 63) m_ovfl++;
            end
            if (pop) begin
                if (m_evt < 63) m_evt++;
                if (!m_fired && m_evt >= th && !m_ev) begin nev = 1; m_fired = 1; end
            end
            m_ev = nev;
        end
        @(posedge clk); #1;
        chk("valid", 32'(fv), 32'(q.size() > 0));
        chk("data", fd, (q.size() > 0) ? q[0] : 32'h0);
        chk("level", 32'(lvl), 32'(q.size()));
        chk("event", 32'(ev), 32'(m_ev));
        chk("evt_cnt", 32'(ecnt), 32'(m_evt));
        chk("ovfl_cnt", 32'(ocnt), 32'(m_ovfl));
    endtask

    task automatic sample(input logic [3:0] c, input logic [3:0] f, input logic [15:0] p);
        valid = 1'b1; chid = c; flags = f; ptr = p;
    endtask

    initial begin
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("idle_level", 32'(lvl), 32'd0);

        en = 1'b1; ready = 1'b1; mask = 32'h0000_0400;
        sample(4'd2, 4'b0110, 16'h0040); cycle();
        chk("first_data", fd, 32'h0206_0040);
        valid = 1'b0; cycle();
        mask = 32'h0000_0800;
        sample(4'd2, 4'b0110, 16'h0040); cycle();
        valid = 1'b0; cycle();
        chk("masked_out", 32'(fv), 32'd0);

        mask = 32'h0000_0400; ready = 1'b0;
        for (int i = 0; i < 6; i++) begin sample(4'd2, 4'b0100, 16'(i + 16'h100)); cycle(); end
        valid = 1'b0;
        chk("full_level", 32'(lvl), 32'd4);
        chk("ovfl_two", 32'(ocnt), 32'd2);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        clr = 1'b1; cycle(); clr = 1'b0;
        thresh = 6'd3; ready = 1'b0;
        for (int i = 0; i < 4; i++) begin sample(4'd2, 4'b0100, 16'(i)); cycle(); end
        ready = 1'b1; sample(4'd2, 4'b0100, 16'h0aa); cycle();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("evt_five", 32'(ecnt), 32'd5);
        ready = 1'b0; clr = 1'b1; cycle(); clr = 1'b0;
        chk("clr_evt", 32'(ecnt), 32'd0);

        for (int i = 0; i < 4; i++) begin sample(4'd2, 4'b0100, 16'(i + 16'h200)); cycle(); end
        ready = 1'b1; sample(4'd2, 4'b0100, 16'h0bb); cycle();
        chk("pp_level", 32'(lvl), 32'd4);
        chk("pp_ovfl", 32'(ocnt), 32'd0);
        ready = 1'b0; mask = '1; sample(4'd9, 4'b1111, 16'h0cc); cycle();
        valid = 1'b0;
        chk("chid9_ovfl", 32'(ocnt), 32'd0);

        thresh = 6'd0; clr = 1'b1; ready = 1'b1; cycle();
        clr = 1'b0; ready = 1'b0;
        chk("clr_pop_event", 32'(ev), 32'd1);
        chk("clr_pop_cnt", 32'(ecnt), 32'd1);
        cycle();

        rst = 1'b1; cycle(); rst = 1'b0; cycle();
        chk("rst_flush", 32'(lvl), 32'd0);

        for (int i = 0; i < 500; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            mask   = $urandom;
            valid  = $urandom_range(0, 1);
            chid   = 4'($urandom_range(0, 9));
            flags  = 4'($urandom);
            ptr    = 16'($urandom);
            ready  = ($urandom_range(0, 2) != 0);
            clr    = ($urandom_range(0, 15) == 0);
            thresh = 6'($urandom_range(0, 4));
            if (i % 100 == 50) rst = 1'b1; else rst = 1'b0;
            cycle();
        end
        rst = 1'b0; clr = 1'b0; valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
